// File: rtl/phy_link_pkg.sv
// Shared link-state encodings and symbol constants for the PHY link controller.
package phy_link_pkg;

    typedef enum logic [1:0] {
        LINK_RESET    = 2'b00,
        LINK_TRAINING = 2'b01,
        LINK_ACTIVE   = 2'b10,
        LINK_RECOVERY = 2'b11
    } link_state_e;

    localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

endpackage

// File: rtl/phy_lane_sync.sv
// Per-lane COM-symbol synchroniser: raises active after COM_COUNT consecutive
// COMs, drops it after ERR_LIMIT consecutive invalid cycles.
module phy_lane_sync
    import phy_link_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int         COM_COUNT  = 4,
    parameter int         ERR_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       active,
    output logic       drop
);

    localparam logic [3:0] COM_N = 4'(COM_COUNT);
    localparam logic [3:0] ERR_N = 4'(ERR_LIMIT);

    logic [3:0] com_cnt_q, com_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       active_q, active_d;

    always_comb begin
        com_cnt_d = com_cnt_q;
        err_cnt_d = err_cnt_q;
        active_d  = active_q;
        drop      = 1'b0;
        if (!enable) begin
            com_cnt_d = 4'd0;
            err_cnt_d = 4'd0;
            active_d  = 1'b0;
        end else if (!active_q) begin
            if (rx_valid) begin
                com_cnt_d = (rx_byte == COM_SYMBOL) ? com_cnt_q + 4'd1 : 4'd0;
            end
            active_d = (com_cnt_d == COM_N);
        end else begin
            // data content is irrelevant once synchronised; only gaps count
            err_cnt_d = rx_valid ? 4'd0 : err_cnt_q + 4'd1;
            if (err_cnt_d == ERR_N) begin
                active_d  = 1'b0;
                com_cnt_d = 4'd0;
                err_cnt_d = 4'd0;
                drop      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_cnt_q <= 4'd0;
            err_cnt_q <= 4'd0;
            active_q  <= 1'b0;
        end else begin
            com_cnt_q <= com_cnt_d;
            err_cnt_q <= err_cnt_d;
            active_q  <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/phy_link_ctrl.sv
// Two-lane link controller: lane synchronisers plus link FSM.
// Optional saturating lane-drop counter under PHY_LINK_CTRL_DROPCNT_EN.
module phy_link_ctrl
    import phy_link_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int         COM_COUNT  = 4,
    parameter int         ERR_LIMIT  = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rx_byte_lane0,
    input  logic       rx_valid_lane0,
    input  logic [7:0] rx_byte_lane1,
    input  logic       rx_valid_lane1,
    output logic       active_lane0,
    output logic       active_lane1,
    output logic       link_up,
    output logic       tx_ready,
    output logic [1:0] link_state,
    output logic [7:0] lane_drop_count
);

    logic        drop0, drop1;
    link_state_e state_q, state_d;
    logic        link_up_q, link_up_d;

    phy_lane_sync #(
        .COM_SYMBOL(COM_SYMBOL),
        .COM_COUNT (COM_COUNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_lane0 (
        .clk     (clk_4f),
        .rst     (reset),
        .enable  (enable),
        .rx_byte (rx_byte_lane0),
        .rx_valid(rx_valid_lane0),
        .active  (active_lane0),
        .drop    (drop0)
    );

    phy_lane_sync #(
        .COM_SYMBOL(COM_SYMBOL),
        .COM_COUNT (COM_COUNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_lane1 (
        .clk     (clk_4f),
        .rst     (reset),
        .enable  (enable),
        .rx_byte (rx_byte_lane1),
        .rx_valid(rx_valid_lane1),
        .active  (active_lane1),
        .drop    (drop1)
    );

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q   <= LINK_RESET;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            link_up_q <= link_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = LINK_RESET;
        end else begin
            unique case (state_q)
                LINK_RESET:    state_d = LINK_TRAINING;
                LINK_TRAINING: if (active_lane0 && active_lane1) state_d = LINK_ACTIVE;
                LINK_ACTIVE:   if (!(active_lane0 && active_lane1)) state_d = LINK_RECOVERY;
                LINK_RECOVERY: if (active_lane0 && active_lane1) state_d = LINK_ACTIVE;
                default:       state_d = LINK_RESET;
            endcase
        end
    end

    // link_up is registered alongside the state so it never glitches
    always_comb begin
        link_up_d = (state_d == LINK_ACTIVE);
    end

    assign link_state = state_q;
    assign link_up    = link_up_q;
    assign tx_ready   = link_up_q;

`ifdef PHY_LINK_CTRL_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 9'(drop0) + 9'(drop1);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign lane_drop_count = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop     = drop0 ^ drop1;
    assign lane_drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Randomised bench for phy_link_ctrl with a run-length reference model.
module tb_phy_link_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_byte_lane0 = 8'h00;
    logic       rx_valid_lane0 = 1'b0;
    logic [7:0] rx_byte_lane1 = 8'h00;
    logic       rx_valid_lane1 = 1'b0;
    logic       active_lane0, active_lane1, link_up, tx_ready;
    logic [1:0] link_state;
    logic [7:0] lane_drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: run lengths of COMs and gaps per lane
    int  com_run [2];
    int  gap_run [2];
    bit  m_act [2];
    int  m_state;
    int  m_drops;

    phy_link_ctrl dut (
        .clk_4f         (clk_4f),
        .reset          (reset),
        .enable         (enable),
        .rx_byte_lane0  (rx_byte_lane0),
        .rx_valid_lane0 (rx_valid_lane0),
        .rx_byte_lane1  (rx_byte_lane1),
        .rx_valid_lane1 (rx_valid_lane1),
        .active_lane0   (active_lane0),
        .active_lane1   (active_lane1),
        .link_up        (link_up),
        .tx_ready       (tx_ready),
        .link_state     (link_state),
        .lane_drop_count(lane_drop_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 2; l++) begin
            com_run[l] = 0;
            gap_run[l] = 0;
            m_act[l]   = 0;
        end
        m_state = 0;
        m_drops = 0;
    endtask

    task automatic model_edge();
        bit v [2];
        bit c [2];
        bit na [2];
        int dropped;
        bit both;
        if (reset) begin
            model_clear();
            return;
        end
        v[0] = rx_valid_lane0;
        v[1] = rx_valid_lane1;
        c[0] = (rx_byte_lane0 == 8'hBC);
        c[1] = (rx_byte_lane1 == 8'hBC);
        dropped = 0;
        for (int l = 0; l < 2; l++) begin
            na[l] = m_act[l];
            if (!enable) begin
                com_run[l] = 0;
                gap_run[l] = 0;
                na[l]      = 0;
            end else if (!m_act[l]) begin
                if (v[l]) com_run[l] = c[l] ? com_run[l] + 1 : 0;
                na[l] = (com_run[l] >= 4);
            end else begin
                gap_run[l] = v[l] ? 0 : gap_run[l] + 1;
                if (gap_run[l] >= 3) begin
                    na[l]      = 0;
                    com_run[l] = 0;
                    gap_run[l] = 0;
                    dropped++;
                end
            end
        end
        both = m_act[0] && m_act[1];
        if (!enable) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = both ? 2 : 1;
        else m_state = both ? 2 : 3;
        m_act[0] = na[0];
        m_act[1] = na[1];
`ifdef PHY_LINK_CTRL_DROPCNT_EN
        m_drops = (m_drops + dropped > 255) ? 255 : m_drops + dropped;
`else
        m_drops = 0;
`endif
    endtask

    task automatic compare_all();
        check("active_lane0", int'(active_lane0), int'(m_act[0]));
        check("active_lane1", int'(active_lane1), int'(m_act[1]));
        check("link_state", int'(link_state), m_state);
        check("link_up", int'(link_up), int'(m_state == 2));
        check("tx_ready", int'(tx_ready), int'(m_state == 2));
        check("drop_count", int'(lane_drop_count), m_drops);
    endtask

    task automatic step(input bit r, input bit en, input bit v0, input logic [7:0] b0,
                        input bit v1, input logic [7:0] b1);
        @(negedge clk_4f);
        reset          = r;
        enable         = en;
        rx_valid_lane0 = v0;
        rx_byte_lane0  = b0;
        rx_valid_lane1 = v1;
        rx_byte_lane1  = b1;
        if (r) begin
            #1;
            check("async_reset", int'({active_lane0, active_lane1, link_up, link_state}), 0);
        end
        @(posedge clk_4f);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] rnd_byte(input int com_pct);
        if (int'($urandom_range(0, 99)) < com_pct) return 8'hBC;
        return 8'($urandom);
    endfunction

    initial begin
        bit en, v0, v1;
        int mode, len;
        logic [7:0] seq0 [8];
        seq0 = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        model_clear();

        // 1: reset held, then released
        repeat (3) step(1, 1, 0, 8'h00, 0, 8'h00);
        check("tp1_state_in_reset", int'(link_state), 0);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        check("tp1_state_training", int'(link_state), 1);

        // 2: four COMs on both lanes
        repeat (4) step(0, 1, 1, 8'hBC, 1, 8'hBC);
        check("tp2_active0", int'(active_lane0), 1);
        check("tp2_linkup_late", int'(link_up), 0);
        step(0, 1, 1, 8'h00, 1, 8'h00);
        check("tp2_linkup", int'(link_up), 1);
        check("tp2_state", int'(link_state), 2);

        // 3: broken COM run on lane 0 restarts the count
        step(0, 0, 0, 8'h00, 0, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, seq0[i], 1, 8'hBC);
            if (i == 6) check("tp3_not_yet", int'(active_lane0), 0);
        end
        check("tp3_active0", int'(active_lane0), 1);
        step(0, 1, 1, 8'h11, 1, 8'h22);
        check("tp3_state", int'(link_state), 2);

        // 4: lane 1 gap drops it, then it resyncs
        repeat (3) step(0, 1, 1, 8'h00, 0, 8'h00);
        check("tp4_active1", int'(active_lane1), 0);
        step(0, 1, 1, 8'h00, 1, 8'h00);
        check("tp4_state", int'(link_state), 3);
`ifdef PHY_LINK_CTRL_DROPCNT_EN
        check("tp4_drops", int'(lane_drop_count), 1);
`endif
        repeat (4) step(0, 1, 1, 8'h00, 1, 8'hBC);
        step(0, 1, 1, 8'h00, 1, 8'h00);
        check("tp4_recovered", int'(link_state), 2);

        // 5: one-cycle enable drop forces retraining
        step(0, 0, 1, 8'hBC, 1, 8'hBC);
        check("tp5_state", int'(link_state), 0);
        check("tp5_act", int'({active_lane0, active_lane1}), 0);
        step(0, 1, 1, 8'h00, 1, 8'h00);
        check("tp5_training", int'(link_state), 1);

`ifdef PHY_LINK_CTRL_DROPCNT_EN
        // 6: double drops and saturation
        repeat (4) step(0, 1, 1, 8'hBC, 1, 8'hBC);
        repeat (3) step(0, 1, 0, 8'h00, 0, 8'h00);
        check("tp6_double", int'(lane_drop_count), 3);
        for (int i = 0; i < 130; i++) begin
            repeat (4) step(0, 1, 1, 8'hBC, 1, 8'hBC);
            repeat (3) step(0, 1, 0, 8'h00, 0, 8'h00);
        end
        check("tp6_saturate", int'(lane_drop_count), 255);
`endif

        // randomised segments
        for (int s = 0; s < 80; s++) begin
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(5, 40));
            for (int c = 0; c < len; c++) begin
                en = 1;
                v0 = 1;
                v1 = 1;
                if (mode == 1) begin
                    v0 = 1'($urandom);
                    v1 = 1'($urandom);
                end else if (mode == 2) begin
                    v0 = ($urandom_range(0, 3) == 0);
                    v1 = ($urandom_range(0, 3) != 0);
                end else if (mode == 3) begin
                    en = ($urandom_range(0, 7) != 0);
                end
                step(($urandom_range(0, 299) == 0), en,
                     v0, rnd_byte(mode == 1 ? 60 : 92),
                     v1, rnd_byte(mode == 1 ? 60 : 92));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
